// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the bus arbiter.
//   arb_state_e     : arbiter FSM state encoding
//   TIMEOUT_DEFAULT : default response-timeout cycle count
package bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_e;

    localparam int TIMEOUT_DEFAULT = 256;

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker.
// Ports:
//   req   : per-channel request vector
//   ptr   : channel index where the search starts (highest priority)
//   grant : one-hot grant of the selected channel (all zero if no request)
//   idx   : binary index of the selected channel
//   any   : at least one request present
module rr_picker #(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  idx,
    output logic              any
);

    // Two passes instead of a modulo walk: first channels at or above ptr,
    // then wrap to the ones below it.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!any && req[i] && (i >= int'(ptr))) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!any && req[i]) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// N-channel round-robin arbiter onto a single downstream request/response
// port, with at most one downstream transaction outstanding.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   clear                        : flush, aborts outstanding work
//   req_valid/req_ready          : per-channel request handshake
//   req_addr/req_we/req_wdata    : packed per-channel request payload
//   resp_valid/resp_data/resp_err: per-channel response pulse, shared data
//   m_req_valid/m_req_ready      : downstream request handshake
//   m_addr/m_we/m_wdata          : downstream payload
//   m_resp_valid/m_resp_data     : downstream response
// Build option: define BUS_ARB_TIMEOUT_EN to enable the response timeout.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | pick a requester, latch its payload
// ST_REQ   | m_req_valid held until downstream accepts
// ST_WAIT  | waiting for the downstream response for the granted channel
// ST_DRAIN | flushed; swallow the pending downstream response
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH-1:0]        req_we,
    input  logic [NUM_CH*DATA_W-1:0] req_wdata,
    output logic [NUM_CH-1:0]        resp_valid,
    output logic [DATA_W-1:0]        resp_data,
    output logic                     resp_err,
    output logic                     m_req_valid,
    input  logic                     m_req_ready,
    output logic [ADDR_W-1:0]        m_addr,
    output logic                     m_we,
    output logic [DATA_W-1:0]        m_wdata,
    input  logic                     m_resp_valid,
    input  logic [DATA_W-1:0]        m_resp_data
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              m_req_valid_q, m_req_valid_d;
    logic [NUM_CH-1:0] resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              resp_fire;

    logic [NUM_CH-1:0] pick_grant;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             resp_err_q, resp_err_d;
    logic             timed_out;
    assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign resp_err  = resp_err_q;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
    assign resp_err       = 1'b0;
`endif

    rr_picker #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_rr_picker (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Accept is combinational so the requester sees it in the same IDLE cycle.
    assign req_ready   = (state_q == ST_IDLE && !clear) ? pick_grant : '0;
    assign resp_valid  = resp_valid_q;
    assign resp_data   = resp_data_q;
    assign m_req_valid = m_req_valid_q;
    assign m_addr      = addr_q;
    assign m_we        = we_q;
    assign m_wdata     = wdata_q;

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        gnt_idx_d     = gnt_idx_q;
        addr_d        = addr_q;
        we_d          = we_q;
        wdata_d       = wdata_q;
        m_req_valid_d = m_req_valid_q;
        resp_valid_d  = '0;
        resp_data_d   = resp_data_q;
        resp_fire     = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
        resp_err_d    = resp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!clear && pick_any) begin
                    gnt_idx_d = pick_idx;
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (pick_grant[i]) begin
                            addr_d  = req_addr[i*ADDR_W +: ADDR_W];
                            we_d    = req_we[i];
                            wdata_d = req_wdata[i*DATA_W +: DATA_W];
                        end
                    end
                    if (pick_idx == IDX_W'(NUM_CH - 1)) rr_ptr_d = '0;
                    else                                rr_ptr_d = pick_idx + IDX_W'(1);
                    m_req_valid_d = 1'b1;
                    state_d       = ST_REQ;
                end
            end
            ST_REQ: begin
                if (m_req_ready) begin
                    m_req_valid_d = 1'b0;
                    state_d       = clear ? ST_DRAIN : ST_WAIT;
                end else if (clear) begin
                    m_req_valid_d = 1'b0;
                    state_d       = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (m_resp_valid) begin
                    state_d = ST_IDLE;
                    if (!clear) begin
                        resp_fire   = 1'b1;
                        resp_data_d = m_resp_data;
`ifdef BUS_ARB_TIMEOUT_EN
                        resp_err_d  = 1'b0;
`endif
                    end
                end else if (clear) begin
                    state_d = ST_DRAIN;
                end
`ifdef BUS_ARB_TIMEOUT_EN
                else if (timed_out) begin
                    state_d     = ST_IDLE;
                    resp_fire   = 1'b1;
                    resp_data_d = '0;
                    resp_err_d  = 1'b1;
                end
`endif
            end
            ST_DRAIN: begin
                if (m_resp_valid) state_d = ST_IDLE;
`ifdef BUS_ARB_TIMEOUT_EN
                else if (timed_out) state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        if (resp_fire) begin
            for (int i = 0; i < NUM_CH; i++) begin
                resp_valid_d[i] = (gnt_idx_q == IDX_W'(i));
            end
        end

`ifdef BUS_ARB_TIMEOUT_EN
        // Restart on every entry to WAIT/DRAIN (including WAIT -> DRAIN).
        if (state_d != state_q && (state_d == ST_WAIT || state_d == ST_DRAIN))
            cnt_d = '0;
        else if (state_q == ST_WAIT || state_q == ST_DRAIN)
            cnt_d = cnt_q + CNT_W'(1);
        else
            cnt_d = cnt_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            gnt_idx_q     <= '0;
            addr_q        <= '0;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            m_req_valid_q <= 1'b0;
            resp_valid_q  <= '0;
            resp_data_q   <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
            resp_err_q    <= 1'b0;
            cnt_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            gnt_idx_q     <= gnt_idx_d;
            addr_q        <= addr_d;
            we_q          <= we_d;
            wdata_q       <= wdata_d;
            m_req_valid_q <= m_req_valid_d;
            resp_valid_q  <= resp_valid_d;
            resp_data_q   <= resp_data_d;
`ifdef BUS_ARB_TIMEOUT_EN
            resp_err_q    <= resp_err_d;
            cnt_q         <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter (NUM_CH=2). Expected downstream
// requests and upstream responses are queued when stimulus is driven and
// compared when the DUT produces them.
module tb_bus_arbiter;

    localparam int NUM_CH  = 2;
    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 64;
    localparam int TIMEOUT = 16;

    logic                     clk;
    logic                     rst;
    logic                     clear;
    logic [NUM_CH-1:0]        req_valid;
    logic [NUM_CH-1:0]        req_ready;
    logic [NUM_CH*ADDR_W-1:0] req_addr;
    logic [NUM_CH-1:0]        req_we;
    logic [NUM_CH*DATA_W-1:0] req_wdata;
    logic [NUM_CH-1:0]        resp_valid;
    logic [DATA_W-1:0]        resp_data;
    logic                     resp_err;
    logic                     m_req_valid;
    logic                     m_req_ready;
    logic [ADDR_W-1:0]        m_addr;
    logic                     m_we;
    logic [DATA_W-1:0]        m_wdata;
    logic                     m_resp_valid;
    logic [DATA_W-1:0]        m_resp_data;

    logic [ADDR_W-1:0] addr_tb  [NUM_CH];
    logic [DATA_W-1:0] wdata_tb [NUM_CH];
    assign req_addr  = {addr_tb[1], addr_tb[0]};
    assign req_wdata = {wdata_tb[1], wdata_tb[0]};

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
    } mreq_t;

    typedef struct {
        int                ch;
        logic [DATA_W-1:0] data;
        logic              err;
    } rsp_t;

    mreq_t mq[$];
    rsp_t  rq[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    bus_arbiter #(
        .NUM_CH  (NUM_CH),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_we       (req_we),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_err     (resp_err),
        .m_req_valid  (m_req_valid),
        .m_req_ready  (m_req_ready),
        .m_addr       (m_addr),
        .m_we         (m_we),
        .m_wdata      (m_wdata),
        .m_resp_valid (m_resp_valid),
        .m_resp_data  (m_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors, sampled mid-cycle.
    always @(negedge clk) begin
        rsp_t  er;
        mreq_t em;
        if (resp_valid != '0) begin
            if (rq.size() == 0) begin
                chk_val("unexpected_resp", 64'(resp_valid), 64'd0);
            end else begin
                er = rq.pop_front();
                chk_val("resp_ch", 64'(resp_valid), 64'd1 << er.ch);
                chk_val("resp_data", resp_data, er.data);
                chk_val("resp_err", 64'(resp_err), 64'(er.err));
            end
        end
        if (m_req_valid && m_req_ready) begin
            if (mq.size() == 0) begin
                chk_val("unexpected_mreq", 64'd1, 64'd0);
            end else begin
                em = mq.pop_front();
                chk_val("m_addr", m_addr, em.addr);
                chk_val("m_we", 64'(m_we), 64'(em.we));
                chk_val("m_wdata", m_wdata, em.wdata);
            end
        end
    end

    // Wait for a grant, check it, and (optionally) complete the downstream
    // handshake. Returns just after the handshake edge, or just after the
    // grant edge when no transfer is expected.
    task automatic grant_hs(input int exp_ch, input int max_wait, input int ready_dly,
                            input logic [NUM_CH-1:0] valid_after, input bit xfer,
                            output bit ok);
        mreq_t m;
        ok = 1'b0;
        for (int i = 0; i <= max_wait; i++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk_val("grant_wait", 64'd0, 64'd1);
            return;
        end
        chk_val("grant", 64'(req_ready), 64'd1 << exp_ch);
        if (xfer) begin
            m.addr  = addr_tb[exp_ch];
            m.we    = req_we[exp_ch];
            m.wdata = wdata_tb[exp_ch];
            mq.push_back(m);
        end
        tick();
        req_valid = valid_after;
        if (!xfer) return;
        for (int i = 0; i < ready_dly; i++) begin
            @(negedge clk);
            chk_val("m_req_hold", 64'(m_req_valid), 64'd1);
            tick();
        end
        m_req_ready = 1'b1;
        tick();
        m_req_ready = 1'b0;
    endtask

    task automatic serve(input int exp_ch, input int max_wait, input int ready_dly,
                         input int resp_dly, input logic [DATA_W-1:0] rdata,
                         input logic [NUM_CH-1:0] valid_after);
        bit   ok;
        rsp_t r;
        grant_hs(exp_ch, max_wait, ready_dly, valid_after, 1'b1, ok);
        if (!ok) return;
        r.ch   = exp_ch;
        r.data = rdata;
        r.err  = 1'b0;
        rq.push_back(r);
        repeat (resp_dly) tick();
        m_resp_valid = 1'b1;
        m_resp_data  = rdata;
        tick();
        m_resp_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        bit   ok;
        rsp_t r;
        int   n;
        bit   seen;

        rst          = 1'b1;
        clear        = 1'b0;
        req_valid    = '0;
        req_we       = 2'b01;
        m_req_ready  = 1'b0;
        m_resp_valid = 1'b0;
        m_resp_data  = '0;
        addr_tb[0]   = 64'h0000_0000_1000_0000;
        addr_tb[1]   = 64'h0000_0000_2000_0000;
        wdata_tb[0]  = 64'h1111_2222_3333_4444;
        wdata_tb[1]  = 64'h5555_6666_7777_8888;

        repeat (3) tick();
        @(negedge clk);
        chk_val("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk_val("rst_resp_data", resp_data, 64'd0);
        chk_val("rst_resp_err", 64'(resp_err), 64'd0);
        chk_val("rst_m_req_valid", 64'(m_req_valid), 64'd0);
        chk_val("rst_m_addr", m_addr, 64'd0);
        chk_val("rst_m_wdata", m_wdata, 64'd0);
        tick();
        rst = 1'b0;

        // Round robin with both channels requesting: ch0, ch1, ch0.
        req_valid = 2'b11;
        serve(0, 2, 0, 1, 64'hA0, 2'b11);
        serve(1, 0, 1, 2, 64'hA1, 2'b11);
        serve(0, 0, 0, 1, 64'hA2, 2'b00);

        // ch1 read with delayed downstream accept.
        addr_tb[1] = 64'h0000_0000_8000_1000;
        req_we     = 2'b00;
        req_valid  = 2'b10;
        serve(1, 3, 3, 2, 64'hDEAD, 2'b00);

        // Clear in REQ before accept: no transfer, no response.
        req_valid = 2'b01;
        grant_hs(0, 3, 0, 2'b00, 1'b0, ok);
        clear = 1'b1;
        @(negedge clk);
        chk_val("clr_req_mvalid", 64'(m_req_valid), 64'd1);
        tick();
        clear = 1'b0;
        @(negedge clk);
        chk_val("clr_idle_mvalid", 64'(m_req_valid), 64'd0);
        tick();
        m_resp_valid = 1'b1;
        m_resp_data  = 64'hBAD0;
        tick();
        m_resp_valid = 1'b0;
        req_valid    = 2'b01;
        clear        = 1'b1;
        @(negedge clk);
        chk_val("clear_blocks_ready", 64'(req_ready), 64'd0);
        tick();
        clear     = 1'b0;
        req_valid = 2'b00;

        // Clear in WAIT, response 5 cycles later is dropped, next request
        // is accepted immediately afterwards.
        req_valid = 2'b10;
        grant_hs(1, 3, 0, 2'b01, 1'b1, ok);
        clear = 1'b1;
        @(negedge clk);
        chk_val("wait_ready0", 64'(req_ready), 64'd0);
        tick();
        clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_val("drain_ready0", 64'(req_ready), 64'd0);
            tick();
        end
        m_resp_valid = 1'b1;
        m_resp_data  = 64'hBAD1;
        tick();
        m_resp_valid = 1'b0;
        serve(0, 0, 0, 1, 64'hC0, 2'b00);

`ifdef BUS_ARB_TIMEOUT_EN
        // No response: error pulse 16 cycles after WAIT entry.
        req_valid = 2'b10;
        grant_hs(1, 3, 0, 2'b00, 1'b1, ok);
        r.ch   = 1;
        r.data = '0;
        r.err  = 1'b1;
        rq.push_back(r);
        seen = 1'b0;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (resp_valid != '0) begin
                seen = 1'b1;
                break;
            end
        end
        chk_val("timeout_seen", 64'(seen), 64'd1);
        chk_val("timeout_cycles", 64'(n), 64'd16);
        tick();
        m_resp_valid = 1'b1;
        m_resp_data  = 64'hBAD2;
        tick();
        m_resp_valid = 1'b0;
`endif

        // Reset in WAIT: outputs return to reset values, rr pointer to 0.
        req_we    = 2'b01;
        req_valid = 2'b01;
        grant_hs(0, 3, 0, 2'b00, 1'b1, ok);
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk_val("rstw_resp_valid", 64'(resp_valid), 64'd0);
        chk_val("rstw_resp_data", resp_data, 64'd0);
        chk_val("rstw_resp_err", 64'(resp_err), 64'd0);
        chk_val("rstw_m_req_valid", 64'(m_req_valid), 64'd0);
        chk_val("rstw_m_addr", m_addr, 64'd0);
        chk_val("rstw_m_we", 64'(m_we), 64'd0);
        chk_val("rstw_m_wdata", m_wdata, 64'd0);
        tick();
        rst          = 1'b0;
        m_resp_valid = 1'b1;
        m_resp_data  = 64'hBAD3;
        tick();
        m_resp_valid = 1'b0;
        req_valid    = 2'b11;
        serve(0, 0, 0, 1, 64'hE0, 2'b00);

        repeat (3) tick();
        chk_val("rsp_q_empty", 64'(rq.size()), 64'd0);
        chk_val("mreq_q_empty", 64'(mq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
